// File: rtl/ram_cmd_arbiter.sv
// Two-requester round-robin arbiter that expands read/write transactions into RAM command words.
// Optional ARB_ADDR_CACHE_EN skips the address command when the RAM already holds the address.
module ram_cmd_arbiter (
   input  logic       CLK,
   input  logic       rst_n,
   input  logic       req0_valid_i,
   output logic       req0_ready_o,
   input  logic       req0_wr_i,
   input  logic [7:0] req0_addr_i,
   input  logic [7:0] req0_wdata_i,
   output logic       rsp0_valid_o,
   output logic [7:0] rsp0_rdata_o,
   input  logic       req1_valid_i,
   output logic       req1_ready_o,
   input  logic       req1_wr_i,
   input  logic [7:0] req1_addr_i,
   input  logic [7:0] req1_wdata_i,
   output logic       rsp1_valid_o,
   output logic [7:0] rsp1_rdata_o,
   output logic [9:0] ram_din_o,
   output logic       ram_rx_valid_o,
   input  logic       ram_tx_valid_i,
   input  logic [7:0] ram_dout_i,
   output logic       busy_o,
   output logic       grant_id_o
);

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic [1:0] CMD_WADDR = 2'b00;
   localparam logic [1:0] CMD_WDATA = 2'b01;
   localparam logic [1:0] CMD_RADDR = 2'b10;
   localparam logic [1:0] CMD_READ  = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_CMD  = 3'd4,
      RD_WAIT = 3'd5
   } state_t;

   state_t            state_q;
   logic              last_grant_q;
   logic              grant_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [9:0]        din_q;
   logic              rx_valid_q;
   logic              rsp0_valid_q;
   logic              rsp1_valid_q;
   logic [DATA_W-1:0] rsp0_rdata_q;
   logic [DATA_W-1:0] rsp1_rdata_q;

   logic              win_id_d;
   logic              accept_d;
   logic              sel_wr_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [DATA_W-1:0] sel_wdata_d;
   logic              wr_hit_d;
   logic              rd_hit_d;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      win_id_d     = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
      accept_d     = (state_q == IDLE) && (req0_valid_i || req1_valid_i);
      req0_ready_o = accept_d && !win_id_d;
      req1_ready_o = accept_d && win_id_d;
      sel_wr_d     = win_id_d ? req1_wr_i    : req0_wr_i;
      sel_addr_d   = win_id_d ? req1_addr_i  : req0_addr_i;
      sel_wdata_d  = win_id_d ? req1_wdata_i : req0_wdata_i;
   end

`ifdef ARB_ADDR_CACHE_EN
   logic              wc_vld_q;
   logic              rc_vld_q;
   logic [ADDR_W-1:0] wc_addr_q;
   logic [ADDR_W-1:0] rc_addr_q;

   assign wr_hit_d = wc_vld_q && (wc_addr_q == sel_addr_d);
   assign rd_hit_d = rc_vld_q && (rc_addr_q == sel_addr_d);

   // Mirrors the RAM's separate write/read address registers; a hit leaves the entry unchanged.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         wc_vld_q  <= 1'b0;
         rc_vld_q  <= 1'b0;
         wc_addr_q <= '0;
         rc_addr_q <= '0;
      end else if (accept_d) begin
         if (sel_wr_d) begin
            wc_vld_q  <= 1'b1;
            wc_addr_q <= sel_addr_d;
         end else begin
            rc_vld_q  <= 1'b1;
            rc_addr_q <= sel_addr_d;
         end
      end
   end
`else
   assign wr_hit_d = 1'b0;
   assign rd_hit_d = 1'b0;
`endif

   // Command word is registered together with the state it belongs to.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         din_q        <= '0;
         rx_valid_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp1_rdata_q <= '0;
      end else begin
         din_q        <= '0;
         rx_valid_q   <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept_d) begin
                  grant_q      <= win_id_d;
                  last_grant_q <= win_id_d;
                  addr_q       <= sel_addr_d;
                  wdata_q      <= sel_wdata_d;
                  rx_valid_q   <= 1'b1;
                  if (sel_wr_d) begin
                     if (wr_hit_d) begin
                        state_q <= WR_DATA;
                        din_q   <= {CMD_WDATA, sel_wdata_d};
                     end else begin
                        state_q <= WR_ADDR;
                        din_q   <= {CMD_WADDR, sel_addr_d};
                     end
                  end else if (rd_hit_d) begin
                     state_q <= RD_CMD;
                     din_q   <= {CMD_READ, 8'h00};
                  end else begin
                     state_q <= RD_ADDR;
                     din_q   <= {CMD_RADDR, sel_addr_d};
                  end
               end
            end
            WR_ADDR: begin
               state_q    <= WR_DATA;
               din_q      <= {CMD_WDATA, wdata_q};
               rx_valid_q <= 1'b1;
            end
            WR_DATA: begin
               state_q      <= IDLE;
               rsp0_valid_q <= !grant_q;
               rsp1_valid_q <= grant_q;
            end
            RD_ADDR: begin
               state_q    <= RD_CMD;
               din_q      <= {CMD_READ, 8'h00};
               rx_valid_q <= 1'b1;
            end
            RD_CMD: begin
               state_q <= RD_WAIT;
            end
            RD_WAIT: begin
               if (ram_tx_valid_i) begin
                  state_q <= IDLE;
                  if (grant_q) begin
                     rsp1_valid_q <= 1'b1;
                     rsp1_rdata_q <= ram_dout_i;
                  end else begin
                     rsp0_valid_q <= 1'b1;
                     rsp0_rdata_q <= ram_dout_i;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ram_din_o      = din_q;
   assign ram_rx_valid_o = rx_valid_q;
   assign rsp0_valid_o   = rsp0_valid_q;
   assign rsp1_valid_o   = rsp1_valid_q;
   assign rsp0_rdata_o   = rsp0_rdata_q;
   assign rsp1_rdata_o   = rsp1_rdata_q;
   assign busy_o         = (state_q != IDLE);
   assign grant_id_o     = grant_q;

endmodule
